// File: rtl/nibble_serial_adder_if.sv
// Start/busy/done handshake bundle for the nibble-serial adder.
// The master drives a request and operands; the slave returns status and the registered result.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
) ();
  // Handshake: start is sampled on a rising edge only while the slave is idle or in its done cycle;
  // busy stays high from the accepting edge until the completion edge, and done is a one-cycle pulse
  // that marks sum/carry_out/overflow as newly valid. A start seen while busy is dropped.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, a, b, carry_in,
    output busy, done, sum, carry_out, overflow
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses a single 4-bit ripple-carry slice, one nibble per clock,
// LSB nibble first, with the carry registered between nibbles.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_serial_adder_if.slave  bus,
  output logic [1:0]            state_dbg
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] work;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_out_q;
  logic             overflow_q;

  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       slice_sum;
  logic [4:0]       rc;
  logic [WIDTH-1:0] work_next;

  // rc[3] is the carry into the slice MSB; on the last nibble that is the carry into bit WIDTH-1.
  always_comb begin
    nib_a     = a_q[{idx, 2'b00} +: 4];
    nib_b     = b_q[{idx, 2'b00} +: 4];
    slice_sum = '0;
    rc        = '0;
    rc[0]     = carry_q;
    for (int i = 0; i < 4; i++) begin
      slice_sum[i] = nib_a[i] ^ nib_b[i] ^ rc[i];
      rc[i+1]      = (nib_a[i] & nib_b[i]) | (rc[i] & (nib_a[i] ^ nib_b[i]));
    end
  end

  always_comb begin
    work_next                     = work;
    work_next[{idx, 2'b00} +: 4]  = slice_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx         <= '0;
      work        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.carry_in;
            idx     <= '0;
            work    <= '0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          work    <= work_next;
          carry_q <= rc[4];
          idx     <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            state       <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            sum_q       <= work_next;
            carry_out_q <= rc[4];
            overflow_q  <= rc[3] ^ rc[4];
          end
        end
        DONE: begin
          done_q <= 1'b0;
          // Accepting here gives back-to-back operation without an IDLE cycle.
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.carry_in;
            idx     <= '0;
            work    <= '0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16): scoreboard of {overflow, carry_out, sum}
// filled when a request is driven and drained on every done pulse.
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;

  nibble_serial_adder_if #(.WIDTH(W)) ifc ();

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifc),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  logic [W+1:0] exp_q[$];
  logic [W+1:0] last_res;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    logic [W:0] f;
    logic       ovf;
    f   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    ovf = (x[W-1] == y[W-1]) && (f[W-1] != x[W-1]);
    return {ovf, f[W], f[W-1:0]};
  endfunction

  // scoreboard: compare on every done pulse
  always @(negedge clk) begin
    if (rst_n && ifc.done) begin
      logic [W+1:0] e;
      done_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(ifc.done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sum",       32'(ifc.sum),       32'(e[W-1:0]));
        chk("carry_out", 32'(ifc.carry_out), 32'(e[W]));
        chk("overflow",  32'(ifc.overflow),  32'(e[W+1]));
        last_res = e;
      end
    end
  end

  // driver: one request, then watch busy length and result stability until done
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input string tag);
    int  busy_cnt;
    bit  got;
    ifc.a        = ta;
    ifc.b        = tb_v;
    ifc.carry_in = tc;
    ifc.start    = 1'b1;
    exp_q.push_back(model(ta, tb_v, tc));
    @(posedge clk); #1;
    ifc.start    = 1'b0;
    ifc.a        = W'($urandom_range(0, 65535));
    ifc.b        = W'($urandom_range(0, 65535));
    ifc.carry_in = 1'($urandom_range(0, 1));
    busy_cnt = 0;
    got      = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ifc.done) begin
        got = 1'b1;
      end else if (ifc.busy) begin
        busy_cnt++;
        chk({tag, "_hold"}, 32'({ifc.overflow, ifc.carry_out, ifc.sum}), 32'(last_res));
      end
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
  endtask

  task automatic wait_done(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ifc.done) got = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
  endtask

  initial begin
    int   d0;
    time  t_first;
    time  t_second;
    bit   first_seen;

    rst_n        = 1'b0;
    ifc.start    = 1'b0;
    ifc.a        = '0;
    ifc.b        = '0;
    ifc.carry_in = 1'b0;
    last_res     = '0;
    t_first      = 0;
    t_second     = 0;

    // reset values
    #1;
    chk("rst_busy",      32'(ifc.busy),      32'd0);
    chk("rst_done",      32'(ifc.done),      32'd0);
    chk("rst_sum",       32'(ifc.sum),       32'd0);
    chk("rst_carry_out", 32'(ifc.carry_out), 32'd0);
    chk("rst_overflow",  32'(ifc.overflow),  32'd0);
    chk("rst_state",     32'(state_dbg),     32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic adds, carry and overflow corners
    run_op(16'h00FF, 16'h0001, 1'b0, "ff_plus_1");
    run_op(16'hFFFF, 16'h0001, 1'b0, "wrap");
    run_op(16'hFFFF, 16'h0000, 1'b1, "wrap_cin");
    run_op(16'h7FFF, 16'h0001, 1'b0, "pos_ovf");
    run_op(16'h8000, 16'h8000, 1'b0, "neg_ovf");
    run_op(16'h1357, 16'hECA8, 1'b1, "mixed");

    // start during busy is ignored
    @(negedge clk);
    d0 = done_count;
    ifc.a = 16'h1234; ifc.b = 16'h1111; ifc.carry_in = 1'b0; ifc.start = 1'b1;
    exp_q.push_back(model(16'h1234, 16'h1111, 1'b0));
    @(posedge clk); #1;
    ifc.start = 1'b0;
    chk("run_state", 32'(state_dbg), 32'd1);
    @(posedge clk); #1;
    ifc.a = 16'hFFFF; ifc.b = 16'hFFFF; ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    wait_done("ignore");
    repeat (10) @(negedge clk);
    chk("ignore_one_done", 32'(done_count - d0), 32'd1);
    chk("ignore_queue_empty", 32'(exp_q.size()), 32'd0);

    // back-to-back with start held high
    @(negedge clk);
    ifc.a = 16'h0001; ifc.b = 16'h0001; ifc.carry_in = 1'b0; ifc.start = 1'b1;
    exp_q.push_back(model(16'h0001, 16'h0001, 1'b0));
    @(posedge clk); #1;
    first_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("b2b_busy_xor_done", 32'(ifc.busy ^ ifc.done), 32'd1);
      if (ifc.done) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          t_first    = $time;
          ifc.a = 16'h0002; ifc.b = 16'h0002;
          exp_q.push_back(model(16'h0002, 16'h0002, 1'b0));
        end else begin
          t_second  = $time;
          ifc.start = 1'b0;
        end
      end
    end
    ifc.start = 1'b0;
    chk("b2b_spacing", 32'(t_second - t_first), 32'd50);
    repeat (3) @(negedge clk);
    chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    // asynchronous reset mid-run
    @(negedge clk);
    d0 = done_count;
    ifc.a = 16'hAAAA; ifc.b = 16'h5555; ifc.carry_in = 1'b0; ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",      32'(ifc.busy),      32'd0);
    chk("arst_sum",       32'(ifc.sum),       32'd0);
    chk("arst_carry_out", 32'(ifc.carry_out), 32'd0);
    chk("arst_overflow",  32'(ifc.overflow),  32'd0);
    chk("arst_state",     32'(state_dbg),     32'd0);
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("arst_no_done", 32'(done_count - d0), 32'd0);
    run_op(16'hAAAA, 16'h5555, 1'b0, "after_rst");

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle adder for WIDTH-bit operands. Processes one 4-bit nibble per clock through an internal 4-bit ripple-carry slice (a + b + cin).
- The carry is registered between nibbles, starting from the least-significant nibble.
- Sits upstream of result consumers. Gives wide additions with a single 4-bit slice in place of a WIDTH-bit combinational chain.
- Uses a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived count of add cycles. Local parameter, not overridable.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an addition; sampled on the rising edge.
- a  input  WIDTH  operand A; sampled only on the edge that accepts start.
- b  input  WIDTH  operand B; sampled only on the edge that accepts start.
- carry_in  input  1  initial carry; sampled only on the edge that accepts start.
- busy  output  1  high while nibbles are being added.
- done  output  1  single-cycle pulse when a new result is valid.
- sum  output  WIDTH  result register.
- carry_out  output  1  carry out of the most-significant nibble.
- overflow  output  1  signed overflow flag: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, carry_out=0, overflow=0.
  - Operand latches, nibble index and running carry are all cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge moves to RUN.
  - On that edge: latch a, b and carry_in; set nibble index to 0; set busy=1.
- RUN:
  - Each edge adds nibble[idx] of a, of b, and the running carry.
  - The 4-bit sum is written into the working result at bits [4*idx+3 : 4*idx].
  - The running carry takes the slice carry out; idx increments.
  - On the edge that processes idx = NIBBLES-1, the next state is DONE and these register updates happen:
    - busy becomes 0 and done becomes 1.
    - sum takes the full working result.
    - carry_out takes the final slice carry.
    - overflow takes (carry into bit WIDTH-1) XOR (final carry).
- Latency: start accepted at edge E0 means done=1 in the cycle after edge E(NIBBLES). With WIDTH=16, done is visible after the 4th edge following acceptance.
- DONE:
  - Lasts exactly one cycle with done=1.
  - start=1 in this cycle is accepted: RUN begins immediately, giving back-to-back operation with no IDLE cycle. Otherwise the next state is IDLE.
- start while busy=1 is ignored. No queueing, and the operands in flight are unaffected.
- Output stability:
  - sum, carry_out and overflow change only on the completion edge.
  - While busy they hold the previous result.
  - Inputs a, b and carry_in may change freely after the accepting edge.
- Reset mid-operation aborts the addition immediately. No done pulse is produced and all outputs return to their reset values.
- Arithmetic is unsigned modulo 2^WIDTH. {carry_out, sum} equals a + b + carry_in exactly.
- No combinational path from any input to any output. All outputs are registered.

Test Plan:
- Reset, then WIDTH=16, a=0x00FF, b=0x0001, cin=0, start for 1 cycle -> busy high for 4 cycles; done pulses once; sum=0x0100, carry_out=0, overflow=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, carry_out=1, overflow=0. Also a=0xFFFF, b=0x0000, cin=1 -> same result (exercises the carry_in path).
- a=0x7FFF, b=0x0001 -> sum=0x8000, carry_out=0, overflow=1. Then a=0x8000, b=0x8000 -> sum=0x0000, carry_out=1, overflow=1.
- Start 0x1234+0x1111, then pulse start with a=0xFFFF, b=0xFFFF on the 2nd busy cycle -> second request ignored; result 0x2345, carry_out=0; exactly one done.
- Hold start high continuously, changing operands on each done cycle (0x0001+0x0001, then 0x0002+0x0002) -> consecutive results 0x0002 and 0x0004; done pulses 5 cycles apart; busy low only during the done cycles.
- Start 0xAAAA+0x5555, assert rst_n=0 asynchronously mid-RUN (between edges) -> outputs zero immediately; no done after release; a fresh start afterwards yields 0xFFFF, carry_out=0.
